// File: rtl/controlador_sequenciador.sv
// controlador_sequenciador: SAP-1 controller-sequencer.
// A six-state ring counter (T1..T6) steps through fetch and execute.
// Each state, combined with the opcode in the instruction register, decodes
// to the datapath control word.
// Optional feature macro: STEP_MODE_EN adds a WAIT state. That state is
// entered after T6 and after reset, and a Step pulse releases it so that
// exactly one instruction runs per pulse.
module controlador_sequenciador #(
    parameter logic [3:0] OP_LDA = 4'b0000,
    parameter logic [3:0] OP_ADD = 4'b0001,
    parameter logic [3:0] OP_SUB = 4'b0010,
    parameter logic [3:0] OP_JMP = 4'b0011,
    parameter logic [3:0] OP_OUT = 4'b1110,
    parameter logic [3:0] OP_HLT = 4'b1111
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [3:0] Opcode,
    input  logic       Step,
    output logic [5:0] T,
    output logic       Cp,
    output logic       Ep,
    output logic       Ej,
    output logic       Lm,
    output logic       Ce,
    output logic       Li,
    output logic       Ei,
    output logic       La,
    output logic       Ea,
    output logic       Su,
    output logic       Eu,
    output logic       Lb,
    output logic       Lo,
    output logic       Hlt
);

    typedef enum logic [2:0] {
        S_WAIT = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_T4   = 3'd4,
        S_T5   = 3'd5,
        S_T6   = 3'd6
    } state_t;

    state_t state;
    state_t nextState;
    logic   nextHlt;

`ifdef STEP_MODE_EN
    localparam state_t RESET_STATE = S_WAIT;
    localparam logic [5:0] RESET_RING = 6'b000000;
`else
    localparam state_t RESET_STATE = S_T1;
    localparam logic [5:0] RESET_RING = 6'b000001;
    // Step has no role when free running.
    logic stepUnused;
    assign stepUnused = Step;
`endif

    // Map a state onto its one-hot ring code. WAIT maps to all zeros.
    function automatic logic [5:0] ringOf(input state_t s);
        logic [5:0] r;
        r = 6'b000000;
        case (s)
            S_T1:    r = 6'b000001;
            S_T2:    r = 6'b000010;
            S_T3:    r = 6'b000100;
            S_T4:    r = 6'b001000;
            S_T5:    r = 6'b010000;
            S_T6:    r = 6'b100000;
            default: r = 6'b000000;
        endcase
        return r;
    endfunction

    // Next-state logic. A halted controller freezes in T5. HLT latches the
    // halt when it leaves T4, so the ring still lands in T5 as it stops.
    always_comb begin
        nextState = state;
        nextHlt   = Hlt;
        if (!Hlt) begin
            case (state)
                S_T1: nextState = S_T2;
                S_T2: nextState = S_T3;
                S_T3: nextState = S_T4;
                S_T4: begin
                    nextState = S_T5;
                    if (Opcode == OP_HLT) nextHlt = 1'b1;
                end
                S_T5: nextState = S_T6;
`ifdef STEP_MODE_EN
                S_T6:   nextState = S_WAIT;
                S_WAIT: nextState = Step ? S_T1 : S_WAIT;
`else
                S_T6:   nextState = S_T1;
`endif
                default: nextState = RESET_STATE;
            endcase
        end
    end

    // State, ring output and halt flag are registered together; clear wins over everything.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state <= RESET_STATE;
            T     <= RESET_RING;
            Hlt   <= 1'b0;
        end else begin
            state <= nextState;
            T     <= ringOf(nextState);
            Hlt   <= nextHlt;
        end
    end

    // Control word decode from the ring state and opcode; halt or WAIT forces everything low.
    always_comb begin
        Cp = 1'b0;
        Ep = 1'b0;
        Ej = 1'b0;
        Lm = 1'b0;
        Ce = 1'b0;
        Li = 1'b0;
        Ei = 1'b0;
        La = 1'b0;
        Ea = 1'b0;
        Su = 1'b0;
        Eu = 1'b0;
        Lb = 1'b0;
        Lo = 1'b0;
        if (!Hlt) begin
            case (state)
                S_T1: begin
                    Ep = 1'b1;
                    Lm = 1'b1;
                end
                S_T2: Cp = 1'b1;
                S_T3: begin
                    Ce = 1'b1;
                    Li = 1'b1;
                end
                S_T4: begin
                    if (Opcode == OP_LDA || Opcode == OP_ADD || Opcode == OP_SUB) begin
                        Ei = 1'b1;
                        Lm = 1'b1;
                    end else if (Opcode == OP_JMP) begin
                        Ei = 1'b1;
                        Ej = 1'b1;
                    end else if (Opcode == OP_OUT) begin
                        Ea = 1'b1;
                        Lo = 1'b1;
                    end
                end
                S_T5: begin
                    if (Opcode == OP_LDA) begin
                        Ce = 1'b1;
                        La = 1'b1;
                    end else if (Opcode == OP_ADD || Opcode == OP_SUB) begin
                        Ce = 1'b1;
                        Lb = 1'b1;
                    end
                end
                S_T6: begin
                    if (Opcode == OP_ADD) begin
                        Eu = 1'b1;
                        La = 1'b1;
                    end else if (Opcode == OP_SUB) begin
                        Su = 1'b1;
                        Eu = 1'b1;
                        La = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_sequenciador.sv
// tb_controlador_sequenciador: directed bench for the SAP-1 controller-sequencer (free-running build).
module tb_controlador_sequenciador;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_JMP = 4'b0011;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;
    localparam logic [3:0] OP_UND = 4'b0101;

    // Control word bit positions: {Cp,Ep,Ej,Lm,Ce,Li,Ei,La,Ea,Su,Eu,Lb,Lo}
    localparam logic [12:0] C_CP = 13'h1000;
    localparam logic [12:0] C_EP = 13'h0800;
    localparam logic [12:0] C_EJ = 13'h0400;
    localparam logic [12:0] C_LM = 13'h0200;
    localparam logic [12:0] C_CE = 13'h0100;
    localparam logic [12:0] C_LI = 13'h0080;
    localparam logic [12:0] C_EI = 13'h0040;
    localparam logic [12:0] C_LA = 13'h0020;
    localparam logic [12:0] C_EA = 13'h0010;
    localparam logic [12:0] C_SU = 13'h0008;
    localparam logic [12:0] C_EU = 13'h0004;
    localparam logic [12:0] C_LB = 13'h0002;
    localparam logic [12:0] C_LO = 13'h0001;

    localparam logic [5:0] R1 = 6'b000001;
    localparam logic [5:0] R2 = 6'b000010;
    localparam logic [5:0] R3 = 6'b000100;
    localparam logic [5:0] R4 = 6'b001000;
    localparam logic [5:0] R5 = 6'b010000;
    localparam logic [5:0] R6 = 6'b100000;

    logic       CLK;
    logic       CLR;
    logic [3:0] Opcode;
    logic       Step;
    logic [5:0] T;
    logic       Cp, Ep, Ej, Lm, Ce, Li, Ei, La, Ea, Su, Eu, Lb, Lo, Hlt;
    logic [12:0] ctl;

    int checks;
    int errors;
    logic armed;

    // Small datapath program counter fed by the controller's PC controls.
    logic       pcLoad;
    logic [3:0] pcInit;
    logic [3:0] pcModel;
    localparam logic [3:0] JMP_ADDR = 4'b1010;

    typedef struct {
        logic [3:0]  op;
        logic        clr;
        logic [5:0]  expT;
        logic [12:0] expCtl;
    } vec_t;

    vec_t vecs[$];

    controlador_sequenciador dut (
        .CLK(CLK), .CLR(CLR), .Opcode(Opcode), .Step(Step), .T(T),
        .Cp(Cp), .Ep(Ep), .Ej(Ej), .Lm(Lm), .Ce(Ce), .Li(Li), .Ei(Ei),
        .La(La), .Ea(Ea), .Su(Su), .Eu(Eu), .Lb(Lb), .Lo(Lo), .Hlt(Hlt)
    );

    assign ctl = {Cp, Ep, Ej, Lm, Ce, Li, Ei, La, Ea, Su, Eu, Lb, Lo};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) begin
        if (pcLoad) pcModel <= pcInit;
        else if (Ej) pcModel <= JMP_ADDR;
        else if (Cp) pcModel <= pcModel + 4'd1;
    end

    // Bus-enable checker: at most one driver onto the bus in any cycle.
    always @(negedge CLK) begin
        if (armed) begin
            checks = checks + 1;
            if ($countones({Ep, Ce, Ei, Ea, Eu}) > 1) begin
                errors = errors + 1;
                $display("[TB] FAIL busInvariant enables=%b required at most one high", {Ep, Ce, Ei, Ea, Eu});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout simulation did not finish, required finish before 200000");
        $fatal(1, "[TB] timeout");
    end

    task automatic applyStimulus(input logic [3:0] op, input logic clr);
        Opcode = op;
        CLR    = clr;
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [5:0] expT,
                               input logic expHlt, input logic [12:0] expCtl);
        checks = checks + 1;
        if (T !== expT) begin
            errors = errors + 1;
            $display("[TB] FAIL %s T got %b required %b", name, T, expT);
        end
        checks = checks + 1;
        if (Hlt !== expHlt) begin
            errors = errors + 1;
            $display("[TB] FAIL %s Hlt got %b required %b", name, Hlt, expHlt);
        end
        checks = checks + 1;
        if (ctl !== expCtl) begin
            errors = errors + 1;
            $display("[TB] FAIL %s ctl got %h required %h", name, ctl, expCtl);
        end
    endtask

    task automatic addVec(input logic [3:0] op, input logic clr,
                          input logic [5:0] expT, input logic [12:0] expCtl);
        vec_t v;
        v.op = op; v.clr = clr; v.expT = expT; v.expCtl = expCtl;
        vecs.push_back(v);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        armed  = 1'b0;
        CLR    = 1'b1;
        Step   = 1'b0;
        Opcode = OP_LDA;
        pcLoad = 1'b0;
        pcInit = 4'b0000;

        // LDA from reset, one full instruction and wrap
        addVec(OP_LDA, 1'b1, R1, C_EP | C_LM);
        addVec(OP_LDA, 1'b0, R2, C_CP);
        addVec(OP_LDA, 1'b0, R3, C_CE | C_LI);
        addVec(OP_LDA, 1'b0, R4, C_EI | C_LM);
        addVec(OP_LDA, 1'b0, R5, C_CE | C_LA);
        addVec(OP_LDA, 1'b0, R6, 13'h0000);
        addVec(OP_LDA, 1'b0, R1, C_EP | C_LM);
        // SUB
        addVec(OP_SUB, 1'b0, R2, C_CP);
        addVec(OP_SUB, 1'b0, R3, C_CE | C_LI);
        addVec(OP_SUB, 1'b0, R4, C_EI | C_LM);
        addVec(OP_SUB, 1'b0, R5, C_CE | C_LB);
        addVec(OP_SUB, 1'b0, R6, C_SU | C_EU | C_LA);
        addVec(OP_SUB, 1'b0, R1, C_EP | C_LM);
        // ADD
        addVec(OP_ADD, 1'b0, R2, C_CP);
        addVec(OP_ADD, 1'b0, R3, C_CE | C_LI);
        addVec(OP_ADD, 1'b0, R4, C_EI | C_LM);
        addVec(OP_ADD, 1'b0, R5, C_CE | C_LB);
        addVec(OP_ADD, 1'b0, R6, C_EU | C_LA);
        addVec(OP_ADD, 1'b0, R1, C_EP | C_LM);
        // JMP
        addVec(OP_JMP, 1'b0, R2, C_CP);
        addVec(OP_JMP, 1'b0, R3, C_CE | C_LI);
        addVec(OP_JMP, 1'b0, R4, C_EI | C_EJ);
        addVec(OP_JMP, 1'b0, R5, 13'h0000);
        addVec(OP_JMP, 1'b0, R6, 13'h0000);
        addVec(OP_JMP, 1'b0, R1, C_EP | C_LM);
        // OUT
        addVec(OP_OUT, 1'b0, R2, C_CP);
        addVec(OP_OUT, 1'b0, R3, C_CE | C_LI);
        addVec(OP_OUT, 1'b0, R4, C_EA | C_LO);
        addVec(OP_OUT, 1'b0, R5, 13'h0000);
        addVec(OP_OUT, 1'b0, R6, 13'h0000);
        addVec(OP_OUT, 1'b0, R1, C_EP | C_LM);
        // undefined opcode behaves as NOP but still takes six states
        addVec(OP_UND, 1'b0, R2, C_CP);
        addVec(OP_UND, 1'b0, R3, C_CE | C_LI);
        addVec(OP_UND, 1'b0, R4, 13'h0000);
        addVec(OP_UND, 1'b0, R5, 13'h0000);
        addVec(OP_UND, 1'b0, R6, 13'h0000);
        addVec(OP_UND, 1'b0, R1, C_EP | C_LM);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].op, vecs[i].clr);
            armed = 1'b1;
            checkOutput($sformatf("vec%0d", i), vecs[i].expT, 1'b0, vecs[i].expCtl);
        end

        // HLT: halts after T4, frozen at T5 with all controls low
        applyStimulus(OP_HLT, 1'b0);
        checkOutput("hltT2", R2, 1'b0, C_CP);
        applyStimulus(OP_HLT, 1'b0);
        checkOutput("hltT3", R3, 1'b0, C_CE | C_LI);
        applyStimulus(OP_HLT, 1'b0);
        checkOutput("hltT4", R4, 1'b0, 13'h0000);
        applyStimulus(OP_HLT, 1'b0);
        checkOutput("hltSet", R5, 1'b1, 13'h0000);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(i[0] ? OP_LDA : OP_ADD, 1'b0);
            checkOutput($sformatf("hltHold%0d", i), R5, 1'b1, 13'h0000);
        end
        applyStimulus(OP_ADD, 1'b1);
        checkOutput("hltClr", R1, 1'b0, C_EP | C_LM);

        // CLR during T5 of ADD abandons it; La never rises
        applyStimulus(OP_ADD, 1'b0);
        checkOutput("abT2", R2, 1'b0, C_CP);
        applyStimulus(OP_ADD, 1'b0);
        checkOutput("abT3", R3, 1'b0, C_CE | C_LI);
        applyStimulus(OP_ADD, 1'b0);
        checkOutput("abT4", R4, 1'b0, C_EI | C_LM);
        applyStimulus(OP_ADD, 1'b0);
        checkOutput("abT5", R5, 1'b0, C_CE | C_LB);
        applyStimulus(OP_ADD, 1'b1);
        checkOutput("abClr", R1, 1'b0, C_EP | C_LM);

        // JMP against the PC model: PC preloaded to 3 must hold 1010 at next T1
        pcInit = 4'b0011;
        pcLoad = 1'b1;
        applyStimulus(OP_JMP, 1'b0);
        pcLoad = 1'b0;
        checkOutput("jT2", R2, 1'b0, C_CP);
        applyStimulus(OP_JMP, 1'b0);
        checkOutput("jT3", R3, 1'b0, C_CE | C_LI);
        applyStimulus(OP_JMP, 1'b0);
        checkOutput("jT4", R4, 1'b0, C_EI | C_EJ);
        applyStimulus(OP_JMP, 1'b0);
        applyStimulus(OP_JMP, 1'b0);
        applyStimulus(OP_JMP, 1'b0);
        checkOutput("jT1", R1, 1'b0, C_EP | C_LM);
        checks = checks + 1;
        if (pcModel !== JMP_ADDR) begin
            errors = errors + 1;
            $display("[TB] FAIL jmpPc pc got %b required %b", pcModel, JMP_ADDR);
        end

        @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
